fifo1_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single 128-bit write port of `fifo1` among several producers (convolution/ELM hidden-layer result engines) in the write-clock domain. Each producer offers words on a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives `winc`/`wdata` directly into `fifo1`, honouring `wfull`. It sits between the producer array and the FIFO write side; the read side is untouched.

---
 rtl/fifo1_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo1_wr_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo1_wr_arbiter.sv
// fifo1_wr_arbiter: round-robin arbiter sharing the single fifo1 write port
// among NREQ valid/ready producers in the write-clock domain. An owner keeps
// the port for up to BURST words, then the port returns to IDLE for one
// cycle and the next requester in round-robin order is chosen.
// Optional build macro FIFO_WR_ARB_STATS_EN adds wr_count/stall_count.
module fifo1_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 128,
    parameter int BURST = 8
) (
    input  logic               wclk,
    input  logic               wrst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    grant,
    output logic               busy,
    input  logic               wfull,
    output logic               winc,
    output logic [DW-1:0]      wdata
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [31:0]        wr_count,
    output logic [31:0]        stall_count
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner;
    logic [7:0]    beats;

    logic          owner_valid;
    logic          xfer;
    logic          last_beat;
    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] owner_nxt;

    // Owner-side handshake; everything here is registered state gated by inputs,
    // so an async reset drops winc/req_ready without waiting for a clock.
    always_comb begin
        owner_valid = 1'b0;
        wdata       = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner == PW'(i)) begin
                owner_valid = req_valid[i];
                wdata       = req_data[i*DW +: DW];
            end
        end
        xfer      = (state == GRANT) && owner_valid && !wfull;
        winc      = xfer;
        req_ready = (state == GRANT && !wfull) ? grant : '0;
        busy      = (state == GRANT);
        last_beat = (beats == 8'(BURST - 1));
        owner_nxt = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end

    // Round-robin search: first valid requester starting at rr_ptr, wrapping mod NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = PW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // Arbitration FSM: IDLE picks an owner, GRANT streams until burst end or owner idles.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            owner  <= '0;
            beats  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state <= GRANT;
                        owner <= pick_idx;
                        grant <= NREQ'(1) << pick_idx;
                        beats <= '0;
                    end
                end
                GRANT: begin
                    // A stalled owner (valid & wfull) keeps the port with beats frozen.
                    if ((xfer && last_beat) || (!xfer && !owner_valid)) begin
                        state  <= IDLE;
                        grant  <= '0;
                        rr_ptr <= owner_nxt;
                        beats  <= '0;
                    end else if (xfer) begin
                        beats <= beats + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    // Free-running statistics; both wrap naturally at 2^32.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            if (xfer)
                wr_count <= wr_count + 32'd1;
            if (state == GRANT && owner_valid && wfull)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo1_wr_arbiter.sv
// Directed bench for fifo1_wr_arbiter (NREQ=4, DW=128, BURST=8).
// Producers are modelled as counters emitting tagged words; the fifo side
// is a capture queue filled on every cycle winc is high.
module tb_fifo1_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 128;
    localparam int BURST = 8;

    logic               wclk;
    logic               wrst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic               wfull;
    logic               winc;
    logic [DW-1:0]      wdata;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [31:0]        wr_count;
    logic [31:0]        stall_count;
`endif

    int          checks;
    int          failures;
    int          idx [NREQ];
    int          lim [NREQ];
    logic [NREQ-1:0] en;
    logic [DW-1:0]   cap [$];

    fifo1_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .wclk        (wclk),
        .wrst        (wrst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .grant       (grant),
        .busy        (busy),
        .wfull       (wfull),
        .winc        (winc),
        .wdata       (wdata)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .wr_count    (wr_count),
        .stall_count (stall_count)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [DW-1:0] mk(input int i, input int k);
        return {32'(i), 32'hC0FFEE00, 32'(k), 32'h5A5A5A5A};
    endfunction

    // Producer i offers word idx[i] while enabled and below its limit.
    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = en[i] && (idx[i] < lim[i]);
            req_data[i*DW +: DW]   = mk(i, idx[i]);
        end
    end

    // Producer advances only on a real valid&ready transfer.
    always @(posedge wclk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (wrst)
                idx[i] <= 0;
            else if (req_valid[i] && req_ready[i])
                idx[i] <= idx[i] + 1;
        end
    end

    // Sample at the falling edge, then move to just after the next rising edge.
    task automatic tick(output logic w, output logic [NREQ-1:0] g, output logic [NREQ-1:0] r);
        @(negedge wclk);
        w = winc;
        g = grant;
        r = req_ready;
        if (winc) cap.push_back(wdata);
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset;
        wrst  = 1'b1;
        en    = '0;
        wfull = 1'b0;
        for (int i = 0; i < NREQ; i++) lim[i] = 0;
        cap.delete();
        repeat (2) @(posedge wclk);
        #1;
        wrst = 1'b0;
    endtask

    task automatic test_reset;
        wrst  = 1'b1;
        en    = 4'b1111;
        wfull = 1'b0;
        for (int i = 0; i < NREQ; i++) lim[i] = 5;
        #1;
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (winc !== 1'b0) begin failures++; $display("FAIL reset_winc got=%b exp=0", winc); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
`ifdef FIFO_WR_ARB_STATS_EN
        checks++; if (wr_count !== 32'd0) begin failures++; $display("FAIL reset_wr_count got=%0d exp=0", wr_count); end
        checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count); end
`endif
        do_reset();
    endtask

    // Only req 2 valid with 20 words: 8 / idle / 8 / idle / 4.
    task automatic test_single;
        logic w;
        logic [NREQ-1:0] g, r, ge;
        logic we;
        do_reset();
        lim[2] = 20;
        en     = 4'b0100;
        for (int c = 0; c < 25; c++) begin
            tick(w, g, r);
            ge = ((c >= 1 && c <= 8) || (c >= 10 && c <= 17) || (c >= 19 && c <= 23)) ? 4'b0100 : 4'b0000;
            we = (c >= 1 && c <= 8) || (c >= 10 && c <= 17) || (c >= 19 && c <= 22);
            checks++; if (g !== ge) begin failures++; $display("FAIL single_grant c=%0d got=%b exp=%b", c, g, ge); end
            checks++; if (w !== we) begin failures++; $display("FAIL single_winc c=%0d got=%b exp=%b", c, w, we); end
        end
        checks++; if (cap.size() != 20) begin failures++; $display("FAIL single_count got=%0d exp=20", cap.size()); end
        for (int k = 0; k < cap.size() && k < 20; k++) begin
            checks++; if (cap[k] !== mk(2, k)) begin failures++; $display("FAIL single_data k=%0d got=%h exp=%h", k, cap[k], mk(2, k)); end
        end
`ifdef FIFO_WR_ARB_STATS_EN
        checks++; if (wr_count !== 32'd20) begin failures++; $display("FAIL single_wr_count got=%0d exp=20", wr_count); end
`endif
    endtask

    // All four continuously valid: 0,1,2,3,0 each for 8 beats with one idle gap.
    task automatic test_round_robin;
        logic w;
        logic [NREQ-1:0] g, r, ge;
        do_reset();
        for (int i = 0; i < NREQ; i++) lim[i] = 100;
        en = 4'b1111;
        for (int c = 0; c < 45; c++) begin
            tick(w, g, r);
            ge = (c % 9 == 0) ? 4'b0000 : 4'(1 << ((c / 9) % 4));
            checks++; if (g !== ge) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, g, ge); end
            checks++; if (w !== (ge != 4'b0000)) begin failures++; $display("FAIL rr_winc c=%0d got=%b exp=%b", c, w, (ge != 4'b0000)); end
        end
        checks++; if (cap.size() != 40) begin failures++; $display("FAIL rr_count got=%0d exp=40", cap.size()); end
        for (int k = 0; k < cap.size() && k < 40; k++) begin
            checks++;
            if (cap[k] !== mk((k / 8) % 4, (k / 32) * 8 + k % 8)) begin
                failures++;
                $display("FAIL rr_data k=%0d got=%h exp=%h", k, cap[k], mk((k / 8) % 4, (k / 32) * 8 + k % 8));
            end
        end
    endtask

    // wfull held for 5 cycles at beat 3 of req 1's burst; burst still ends at 8 words.
    task automatic test_full_stall;
        logic w, we;
        logic [NREQ-1:0] g, r, ge;
        do_reset();
        lim[1] = 8;
        en     = 4'b0010;
        for (int c = 0; c < 16; c++) begin
            wfull = (c >= 4 && c <= 8);
            tick(w, g, r);
            ge = (c >= 1 && c <= 13) ? 4'b0010 : 4'b0000;
            we = (c >= 1 && c <= 3) || (c >= 9 && c <= 13);
            checks++; if (g !== ge) begin failures++; $display("FAIL stall_grant c=%0d got=%b exp=%b", c, g, ge); end
            checks++; if (w !== we) begin failures++; $display("FAIL stall_winc c=%0d got=%b exp=%b", c, w, we); end
            checks++; if (r[1] !== we) begin failures++; $display("FAIL stall_ready c=%0d got=%b exp=%b", c, r[1], we); end
        end
        wfull = 1'b0;
        checks++; if (cap.size() != 8) begin failures++; $display("FAIL stall_count_words got=%0d exp=8", cap.size()); end
        for (int k = 0; k < cap.size() && k < 8; k++) begin
            checks++; if (cap[k] !== mk(1, k)) begin failures++; $display("FAIL stall_data k=%0d got=%h exp=%h", k, cap[k], mk(1, k)); end
        end
`ifdef FIFO_WR_ARB_STATS_EN
        checks++; if (stall_count !== 32'd5) begin failures++; $display("FAIL stall_stall_count got=%0d exp=5", stall_count); end
        checks++; if (wr_count !== 32'd8) begin failures++; $display("FAIL stall_wr_count got=%0d exp=8", wr_count); end
`endif
    endtask

    // Owner 0 drops valid after 2 words; req 3 waits; rr_ptr must move past 0.
    task automatic test_owner_drop;
        logic w;
        logic [NREQ-1:0] g, r;
        logic [NREQ-1:0] g_exp [11];
        logic            w_exp [11];
        g_exp = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1000,
                  4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
        w_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        lim[0] = 100;
        lim[3] = 3;
        for (int c = 0; c < 11; c++) begin
            en = (c == 3) ? 4'b1000 : 4'b1001;
            tick(w, g, r);
            checks++; if (g !== g_exp[c]) begin failures++; $display("FAIL drop_grant c=%0d got=%b exp=%b", c, g, g_exp[c]); end
            checks++; if (w !== w_exp[c]) begin failures++; $display("FAIL drop_winc c=%0d got=%b exp=%b", c, w, w_exp[c]); end
        end
    endtask

    // Async reset in the middle of req 2's second burst; arbitration restarts at 0.
    task automatic test_async_reset;
        logic w;
        logic [NREQ-1:0] g, r;
        do_reset();
        lim[2] = 20;
        en     = 4'b0100;
        for (int c = 0; c < 12; c++) tick(w, g, r);
        @(negedge wclk);
        checks++; if (winc !== 1'b1) begin failures++; $display("FAIL areset_pre_winc got=%b exp=1", winc); end
        #2;
        wrst = 1'b1;
        #1;
        checks++; if (winc !== 1'b0) begin failures++; $display("FAIL areset_winc got=%b exp=0", winc); end
        checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL areset_grant got=%b exp=0000", grant); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy got=%b exp=0", busy); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL areset_ready got=%b exp=0000", req_ready); end
        checks++; if (idx[2] != 10) begin failures++; $display("FAIL areset_words got=%0d exp=10", idx[2]); end
        lim[1] = 20;
        lim[3] = 20;
        en     = 4'b1110;
        @(posedge wclk);
        #1;
        wrst = 1'b0;
        tick(w, g, r);
        checks++; if (g !== 4'b0000 || w !== 1'b0) begin failures++; $display("FAIL areset_idle got=%b/%b exp=0000/0", g, w); end
        tick(w, g, r);
        checks++; if (g !== 4'b0010) begin failures++; $display("FAIL areset_restart_grant got=%b exp=0010", g); end
        checks++; if (w !== 1'b1) begin failures++; $display("FAIL areset_restart_winc got=%b exp=1", w); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        wrst     = 1'b1;
        en       = '0;
        wfull    = 1'b0;
        for (int i = 0; i < NREQ; i++) lim[i] = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_owner_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
